// File: rtl/psum_bank_pkg.sv
// Shared TS3D definitions for the psum bank: lane geometry defaults, pass
// state encoding and the per-pass configuration latched on CfgStart.
package psum_bank_pkg;

  localparam int DEPTH_DEF      = 16;
  localparam int LANES_DEF      = 16;
  localparam int PSUM_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int SHIFT_W        = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  typedef struct packed {
    logic               relu;
    logic [SHIFT_W-1:0] shift;
  } cfg_t;

endpackage

// File: rtl/psum_bank_if.sv
// Psum/ofm handshake bundle between the PE block, the psum bank and the
// downstream output consumer. slave = bank side, master = PEB/consumer side.
interface psum_bank_if
  import psum_bank_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                          PSUMGB_val;
  logic [LANES*PSUM_WIDTH-1:0]   PSUMGB_data;
  logic                          GBPSUM_rdy;
  logic                          GBPSUM_val;
  logic [LANES*PSUM_WIDTH-1:0]   GBPSUM_data;
  logic                          PSUMGB_rdy;
  logic                          GBOFM_val;
  logic [LANES*DATA_WIDTH-1:0]   GBOFM_data;
  logic                          OFMGB_rdy;

  modport slave (
    input  PSUMGB_val, PSUMGB_data, PSUMGB_rdy, OFMGB_rdy,
    output GBPSUM_rdy, GBPSUM_val, GBPSUM_data, GBOFM_val, GBOFM_data
  );

  modport master (
    output PSUMGB_val, PSUMGB_data, PSUMGB_rdy, OFMGB_rdy,
    input  GBPSUM_rdy, GBPSUM_val, GBPSUM_data, GBOFM_val, GBOFM_data
  );

endinterface

// File: rtl/psum_quant.sv
// One lane of output quantization: arithmetic shift right, optional ReLU,
// then saturation to the signed DATA_WIDTH range.
module psum_quant
  import psum_bank_pkg::*;
#(
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [PSUM_WIDTH-1:0] psum,
  input  logic        [SHIFT_W-1:0]    shift,
  input  logic                         relu,
  output logic signed [DATA_WIDTH-1:0] q
);

  localparam logic signed [PSUM_WIDTH-1:0] QMAX = PSUM_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PSUM_WIDTH-1:0] QMIN = ~QMAX;

  logic signed [PSUM_WIDTH-1:0] shifted;
  logic signed [PSUM_WIDTH-1:0] rectified;

  always_comb begin
    shifted   = psum >>> shift;
    rectified = shifted;
    if (relu && shifted[PSUM_WIDTH-1]) begin
      rectified = '0;
    end
    if (rectified > QMAX) begin
      q = QMAX[DATA_WIDTH-1:0];
    end else if (rectified < QMIN) begin
      q = QMIN[DATA_WIDTH-1:0];
    end else begin
      q = rectified[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/psum_bank.sv
// Partial-sum bank: FIFO of psum words recirculated to the PE block during
// accumulate passes, and a quantizing one-word output stage for final passes.
module psum_bank
  import psum_bank_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      CfgStart,
  input  logic                      CfgStop,
  input  logic                      CfgLast,
  input  logic [SHIFT_W-1:0]        CfgShift,
  input  logic                      CfgRelu,
  psum_bank_if.slave                bus,
  output logic [$clog2(DEPTH):0]    Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = LANES * PSUM_WIDTH;
  localparam int OW = LANES * DATA_WIDTH;

  state_t state, state_nxt;
  cfg_t   cfg;

  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          psum_rdy, rd_val;
  logic          push, pop, ofm_load;

  logic [OW-1:0] qword;
  logic [OW-1:0] ofm_data;
  logic          ofm_val;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // CfgStart is only looked at in IDLE, which also makes it win over a same-cycle CfgStop.
  always_comb begin
    state_nxt = state;
    psum_rdy  = 1'b0;
    rd_val    = 1'b0;
    unique case (state)
      IDLE: begin
        if (CfgStart) begin
          state_nxt = CfgLast ? OUT : ACC;
        end
      end
      ACC: begin
        psum_rdy = !full;
        rd_val   = !empty;
        if (CfgStop) begin
          state_nxt = IDLE;
        end
      end
      OUT: begin
        psum_rdy = !ofm_val || bus.OFMGB_rdy;
        rd_val   = !empty;
        if (CfgStop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= '0;
    end else if (state == IDLE && CfgStart) begin
      cfg <= '{relu: CfgRelu, shift: CfgShift};
    end
  end

  // Push readiness comes from the pre-pop count, so a full FIFO refuses a push even while popping.
  assign push     = (state == ACC) && bus.PSUMGB_val && psum_rdy;
  assign pop      = rd_val && bus.PSUMGB_rdy;
  assign ofm_load = (state == OUT) && bus.PSUMGB_val && psum_rdy;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.PSUMGB_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psum_quant #(
      .PSUM_WIDTH(PSUM_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_quant (
      .psum  (bus.PSUMGB_data[i*PSUM_WIDTH +: PSUM_WIDTH]),
      .shift (cfg.shift),
      .relu  (cfg.relu),
      .q     (qword[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // The output word drains on OFMGB_rdy in any state, so a word pending at CfgStop is still delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      ofm_val  <= 1'b0;
      ofm_data <= '0;
    end else if (ofm_load) begin
      ofm_val  <= 1'b1;
      ofm_data <= qword;
    end else if (bus.OFMGB_rdy) begin
      ofm_val  <= 1'b0;
    end
  end

  assign bus.GBPSUM_rdy  = psum_rdy;
  assign bus.GBPSUM_val  = rd_val;
  assign bus.GBPSUM_data = mem[rd_ptr];
  assign bus.GBOFM_val   = ofm_val;
  assign bus.GBOFM_data  = ofm_data;
  assign Count           = count;

endmodule

// File: tb/tb_psum_bank.sv
// Directed bench for psum_bank: accumulate FIFO fill/drain, full-with-pop,
// quantize passes with stall, state persistence across passes, and reset.
module tb_psum_bank;
  import psum_bank_pkg::*;

  logic       clk;
  logic       rst;
  logic       CfgStart, CfgStop, CfgLast, CfgRelu;
  logic [4:0] CfgShift;
  logic [4:0] Count;

  int checks = 0;
  int errors = 0;

  logic [511:0] w, e, hold;

  psum_bank_if #(.LANES(16), .PSUM_WIDTH(32), .DATA_WIDTH(8)) bus ();

  psum_bank #(
    .DEPTH(16), .LANES(16), .PSUM_WIDTH(32), .DATA_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .CfgStart (CfgStart),
    .CfgStop  (CfgStop),
    .CfgLast  (CfgLast),
    .CfgShift (CfgShift),
    .CfgRelu  (CfgRelu),
    .bus      (bus.slave),
    .Count    (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mkword(input logic [31:0] v);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [127:0] mkq(input logic [7:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = v;
    return r;
  endfunction

  task automatic start(input logic last, input logic [4:0] sh, input logic relu);
    CfgLast = last; CfgShift = sh; CfgRelu = relu; CfgStart = 1'b1;
    tick();
    CfgStart = 1'b0;
  endtask

  task automatic stop();
    CfgStop = 1'b1;
    tick();
    CfgStop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; CfgStart = 0; CfgStop = 0; CfgLast = 0; CfgShift = '0; CfgRelu = 0;
    bus.PSUMGB_val = 0; bus.PSUMGB_data = '0; bus.PSUMGB_rdy = 0; bus.OFMGB_rdy = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_count", Count, 0);
    chk("rst_gbpsum_rdy", bus.GBPSUM_rdy, 0);
    chk("rst_gbpsum_val", bus.GBPSUM_val, 0);
    chk("rst_gbofm_val", bus.GBOFM_val, 0);
    chk("rst_gbofm_data", bus.GBOFM_data, 0);

    // Accumulate pass: fill FIFO with words 0..15.
    start(1'b0, 5'd0, 1'b0);
    chk("acc_rdy", bus.GBPSUM_rdy, 1);
    chk("acc_val_empty", bus.GBPSUM_val, 0);
    for (int k = 0; k < 16; k++) begin
      bus.PSUMGB_val = 1'b1; bus.PSUMGB_data = mkword(k);
      tick();
    end
    chk("full_count", Count, 16);
    chk("full_rdy", bus.GBPSUM_rdy, 0);
    bus.PSUMGB_data = mkword(16);
    tick();
    chk("held17_count", Count, 16);
    chk("head_word0", bus.GBPSUM_data, mkword(0));

    // Full with simultaneous pop: push refused this cycle, accepted next.
    bus.PSUMGB_rdy = 1'b1;
    tick();
    chk("fullpop_count", Count, 15);
    chk("fullpop_head", bus.GBPSUM_data, mkword(1));
    chk("fullpop_rdy", bus.GBPSUM_rdy, 1);
    tick();
    chk("pushpop_count", Count, 15);
    bus.PSUMGB_val = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      chk("drain_val", bus.GBPSUM_val, 1);
      chk("drain_data", bus.GBPSUM_data, mkword(k));
      tick();
    end
    chk("drained_count", Count, 0);
    chk("drained_val", bus.GBPSUM_val, 0);
    bus.PSUMGB_rdy = 1'b0;

    // Five entries persist across stop/start into a final pass.
    for (int k = 20; k < 25; k++) begin
      bus.PSUMGB_val = 1'b1; bus.PSUMGB_data = mkword(k);
      tick();
    end
    bus.PSUMGB_val = 1'b0;
    chk("five_count", Count, 5);
    stop();
    chk("idle_val", bus.GBPSUM_val, 0);
    chk("idle_rdy", bus.GBPSUM_rdy, 0);
    chk("idle_count", Count, 5);
    start(1'b1, 5'd4, 1'b0);
    chk("out_count", Count, 5);
    chk("out_gbpsum_val", bus.GBPSUM_val, 1);
    chk("out_gbpsum_data", bus.GBPSUM_data, mkword(20));
    chk("out_rdy", bus.GBPSUM_rdy, 1);

    // Quantize shift 4: 0x800->127, -0x900->-128, 0x345->52; then -16->-1 back to back.
    bus.OFMGB_rdy = 1'b1;
    w = '0; w[31:0] = 32'h0000_0800; w[63:32] = 32'hFFFF_F700; w[95:64] = 32'h0000_0345;
    bus.PSUMGB_val = 1'b1; bus.PSUMGB_data = w;
    tick();
    e = '0; e[7:0] = 8'h7F; e[15:8] = 8'h80; e[23:16] = 8'h34;
    chk("q_val1", bus.GBOFM_val, 1);
    chk("q_data1", bus.GBOFM_data, e);
    bus.PSUMGB_data = mkword(32'hFFFF_FFF0);
    tick();
    bus.PSUMGB_val = 1'b0;
    chk("q_val2", bus.GBOFM_val, 1);
    chk("q_data2", bus.GBOFM_data, mkq(8'hFF));
    chk("q_count_kept", Count, 5);
    tick();
    chk("q_val_drained", bus.GBOFM_val, 0);
    stop();

    // ReLU, shift 0, with a 3-cycle downstream stall.
    start(1'b1, 5'd0, 1'b1);
    bus.OFMGB_rdy = 1'b0;
    w = '0; w[31:0] = 32'hFFFF_FFFB; w[63:32] = 32'd100; w[95:64] = 32'd300; w[127:96] = 32'hFFFF_FED4;
    bus.PSUMGB_val = 1'b1; bus.PSUMGB_data = w;
    tick();
    e = '0; e[15:8] = 8'h64; e[23:16] = 8'h7F;
    hold = e;
    bus.PSUMGB_data = mkword(1);
    chk("relu_val", bus.GBOFM_val, 1);
    chk("relu_data", bus.GBOFM_data, hold);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_val", bus.GBOFM_val, 1);
      chk("stall_data", bus.GBOFM_data, hold);
      chk("stall_rdy", bus.GBPSUM_rdy, 0);
    end
    bus.OFMGB_rdy = 1'b1;
    tick();
    bus.PSUMGB_val = 1'b0;
    chk("resume_val", bus.GBOFM_val, 1);
    chk("resume_data", bus.GBOFM_data, mkq(8'h01));

    // Pending output word survives CfgStop until handshake.
    bus.OFMGB_rdy = 1'b0;
    stop();
    chk("pend_val", bus.GBOFM_val, 1);
    chk("pend_rdy", bus.GBPSUM_rdy, 0);
    tick();
    chk("pend_data", bus.GBOFM_data, mkq(8'h01));
    bus.OFMGB_rdy = 1'b1;
    tick();
    chk("pend_drained", bus.GBOFM_val, 0);

    // Reset mid-pass with Count=7 and a pending output word.
    start(1'b0, 5'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      bus.PSUMGB_val = 1'b1; bus.PSUMGB_data = mkword(40 + k);
      tick();
    end
    bus.PSUMGB_val = 1'b0;
    stop();
    start(1'b1, 5'd0, 1'b0);
    bus.OFMGB_rdy = 1'b0;
    bus.PSUMGB_val = 1'b1; bus.PSUMGB_data = mkword(3);
    tick();
    bus.PSUMGB_val = 1'b0;
    chk("prerst_count", Count, 7);
    chk("prerst_ofm_val", bus.GBOFM_val, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", Count, 0);
    chk("midrst_ofm_val", bus.GBOFM_val, 0);
    chk("midrst_ofm_data", bus.GBOFM_data, 0);
    chk("midrst_rdy", bus.GBPSUM_rdy, 0);
    chk("midrst_gbpsum_val", bus.GBPSUM_val, 0);
    start(1'b0, 5'd0, 1'b0);
    chk("postrst_acc_rdy", bus.GBPSUM_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psum_bank.md
PSUM_BANK -- requirements
Module: psum_bank

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 512-bit psum entries held (power of 2).
REQ-002 SHALL have parameter LANES, default 16, psum lanes per word.
REQ-003 SHALL have parameter PSUM_WIDTH, default 32, bits per psum lane.
REQ-004 SHALL have parameter DATA_WIDTH, default 8, bits per quantized output lane.
REQ-005 SHALL have port clk  in  1  sole clock; one clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port CfgStart  in  1  pulse; starts a pass; honoured only in IDLE.
REQ-008 SHALL have port CfgStop  in  1  pulse; ends the current pass.
REQ-009 SHALL have port CfgLast  in  1  sampled on CfgStart; 1 selects final-pass (quantize) mode.
REQ-010 SHALL have port CfgShift  in  5  sampled on CfgStart; arithmetic right-shift amount.
REQ-011 SHALL have port CfgRelu  in  1  sampled on CfgStart; enables ReLU.
REQ-012 SHALL have port PSUMGB_val  in  1  PEB psum word valid.
REQ-013 SHALL have port PSUMGB_data  in  LANES*PSUM_WIDTH  PEB psum word; lane i at [32i+:32], signed.
REQ-014 SHALL have port GBPSUM_rdy  out  1  bank accepts psum word.
REQ-015 SHALL have port GBPSUM_val  out  1  stored psum word valid toward PEB.
REQ-016 SHALL have port GBPSUM_data  out  LANES*PSUM_WIDTH  stored psum word (head of FIFO).
REQ-017 SHALL have port PSUMGB_rdy  in  1  PEB accepts stored psum word.
REQ-018 SHALL have port GBOFM_val  out  1  quantized output word valid.
REQ-019 SHALL have port GBOFM_data  out  LANES*DATA_WIDTH  quantized word; lane i at [8i+:8], signed.
REQ-020 SHALL have port OFMGB_rdy  in  1  downstream accepts quantized word.
REQ-021 SHALL have port Count  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-022 SHALL implement states IDLE, ACC, OUT; IDLE->ACC on CfgStart with CfgLast=0, IDLE->OUT on CfgStart with CfgLast=1; ACC/OUT->IDLE on CfgStop; CfgStart outside IDLE and CfgStop in IDLE are ignored; CfgStart and CfgStop in the same IDLE cycle: CfgStart wins.
REQ-023 SHALL store psums in a DEPTH-entry FIFO with wrap-around pointers; FIFO contents and Count persist across passes and CfgStart/CfgStop.
REQ-024 SHALL drive GBPSUM_val = (state!=IDLE) && Count!=0; GBPSUM_data = head entry (show-ahead); pop on GBPSUM_val && PSUMGB_rdy.
REQ-025 SHALL in ACC drive GBPSUM_rdy = Count!=DEPTH; push on PSUMGB_val && GBPSUM_rdy; write becomes readable the following cycle (no write-through when empty).
REQ-026 SHALL when full, allow simultaneous pop; the push in that cycle is still refused (rdy computed from pre-pop Count); simultaneous push+pop at non-full/non-empty leaves Count unchanged.
REQ-027 SHALL in OUT route accepted psums to a one-entry output register instead of the FIFO; GBPSUM_rdy = !GBOFM_val || OFMGB_rdy; latency PSUMGB handshake -> GBOFM_val is 1 cycle; full throughput when OFMGB_rdy held high.
REQ-028 SHALL quantize each lane: signed arithmetic shift right by CfgShift, then ReLU (negatives->0) if CfgRelu, then saturate to [-128,127].
REQ-029 SHALL drive GBPSUM_rdy = 0 in IDLE.
REQ-030 SHALL hold a pending GBOFM word after CfgStop until OFMGB_rdy handshake.
REQ-031 SHALL keep GBOFM_data stable while GBOFM_val && !OFMGB_rdy.

Reset
REQ-032 SHALL on rst: state=IDLE, pointers=0, Count=0, GBOFM_val=0, GBOFM_data=0, GBPSUM_val=0, GBPSUM_rdy=0, latched cfg=0; rst mid-pass discards FIFO contents and any pending output word; FIFO RAM contents need not be cleared.

Structure
REQ-033 SHALL take LANES, PSUM_WIDTH, DATA_WIDTH defaults and the state enum from the shared TS3D package.
REQ-034 SHALL place the per-lane shift/ReLU/saturate logic in sub-module psum_quant, instantiated LANES times.

Verification
REQ-035 SHALL cover: ACC pass, push 16 words 0..15 (lane value = index) -> Count=16, GBPSUM_rdy=0; 17th held.
REQ-036 SHALL cover: full FIFO, PSUMGB_rdy=1 with PSUMGB_val=1 -> pop word 0, push refused that cycle, accepted next; order 1..15,16 out.
REQ-037 SHALL cover: OUT pass, CfgShift=4, CfgRelu=0, lanes 0x00000800, -0x00000900, 0x00000345 -> GBOFM lanes 127, -128, 52 one cycle later.
REQ-038 SHALL cover: OUT pass, CfgRelu=1, lane -5 shift 0 -> 0; OFMGB_rdy low 3 cycles -> data stable, GBPSUM_rdy=0.
REQ-039 SHALL cover: CfgStop with 5 entries stored, then CfgStart(CfgLast=1) -> Count=5 preserved and readable on GBPSUM.
REQ-040 SHALL cover: rst asserted with Count=7 and GBOFM_val=1 -> next cycle Count=0, GBOFM_val=0, state IDLE.
